// File: rtl/rst_sequencer_if.sv
// -----------------------------------------------------------------------------
// rst_sequencer_if
// Request/status bundle between a reset-control master (software, test logic)
// and the reset sequencer. The master drives the soft-reset and watchdog
// controls. The sequencer drives the core reset, the completion pulse and the
// cause code.
// -----------------------------------------------------------------------------
interface rst_sequencer_if;

    logic       soft_rst_req;   // software reset request, level sampled
    logic       wdt_en;         // watchdog enable
    logic       wdt_kick;       // watchdog restart, level sampled
    logic       core_rst;       // active-high reset to the core
    logic       rst_done;       // one-cycle pulse when core_rst deasserts
    logic [1:0] rst_cause;      // 00 external, 01 soft, 10 watchdog

    modport master (
        output soft_rst_req,
        output wdt_en,
        output wdt_kick,
        input  core_rst,
        input  rst_done,
        input  rst_cause
    );

    modport slave (
        input  soft_rst_req,
        input  wdt_en,
        input  wdt_kick,
        output core_rst,
        output rst_done,
        output rst_cause
    );

endinterface : rst_sequencer_if

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
// Produces a clean, clock-aligned core reset from an asynchronous active-low
// board reset. A 2-flop synchronizer releases the internal reset. The core is
// then held in reset for HOLD_CYCLES clocks, after which it runs.
// While running, a software request or an optional watchdog expiry re-enters
// the hold phase. rst_cause records what caused the most recent core reset.
//
// Build option:
//   RST_WDT_EN  - when defined, the watchdog counter and its expiry path are
//                 compiled in. When undefined, wdt_en/wdt_kick are ignored
//                 and rst_cause never reports a watchdog reset.
// -----------------------------------------------------------------------------
module rst_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16,    // 1..255
    parameter int unsigned WDT_TIMEOUT = 1024   // 2..65535
) (
    input  logic           clk,
    input  logic           rst,                 // async, active-low
    rst_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        SYNC = 2'b00,   // synchronizer filling after board reset release
        HOLD = 2'b01,   // core held in reset, hold counter running
        RUN  = 2'b10    // core out of reset
    } state_t;

    localparam logic [1:0]  CAUSE_EXT  = 2'b00;
    localparam logic [1:0]  CAUSE_SOFT = 2'b01;
    localparam logic [1:0]  CAUSE_WDT  = 2'b10;

    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] WDT_LAST   = 16'(WDT_TIMEOUT - 1);

    logic [1:0] sync_ff;
    logic       sync_release;
    state_t     state;
    logic [7:0] hold_cnt;
    logic       core_rst_q;
    logic       rst_done_q;
    logic [1:0] rst_cause_q;
    logic       wdt_expire;

    // Release synchronizer: clears asynchronously with rst and fills with ones
    // on the clock, so the internal reset always ends on a clock edge.
    // NOTE: every clocked block uses non-blocking (<=) assignments so that all
    // flops sample the pre-edge values, exactly like the real hardware.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], 1'b1};
        end
    end

    // Synchronizer completes on this edge. The first stage is already set, and
    // the second stage is about to follow.
    assign sync_release = (sync_ff == 2'b01);

`ifdef RST_WDT_EN
    logic [15:0] wdt_cnt;

    // Watchdog counter: advances only while the core runs with the watchdog
    // armed. Any kick, disarm, reset request or exit from RUN clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt <= '0;
        end else if (state != RUN || !bus.wdt_en || bus.wdt_kick ||
                     bus.soft_rst_req || wdt_expire) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 16'd1;
        end
    end

    // Expiry rules: a kick on the terminal count cancels the expiry. A
    // concurrent soft request takes priority, so the cause reported is soft.
    assign wdt_expire = (state == RUN) && (wdt_cnt == WDT_LAST) &&
                        !bus.wdt_kick && !bus.soft_rst_req;
`else
    assign wdt_expire = 1'b0;

    // Watchdog controls are accepted at the boundary but have no effect here.
    logic unused_wdt;
    assign unused_wdt = &{1'b0, bus.wdt_en, bus.wdt_kick, WDT_LAST};
`endif

    // Sequencer FSM with registered outputs. The board reset forces SYNC
    // asynchronously. Leaving SYNC is gated by the synchronizer, so releasing
    // rst between clock edges cannot disturb the state.
    // NOTE: state and outputs are cleared asynchronously so that core_rst is 1
    // from the instant rst falls. The only exit from SYNC is the synchronized
    // release, which keeps deassertion glitch-free and edge-aligned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SYNC;
            hold_cnt    <= '0;
            core_rst_q  <= 1'b1;
            rst_done_q  <= 1'b0;
            rst_cause_q <= CAUSE_EXT;
        end else begin
            rst_done_q <= 1'b0;
            case (state)
                SYNC: begin
                    core_rst_q <= 1'b1;
                    if (sync_release) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end

                // Requests arriving during the hold are ignored on purpose,
                // so the hold length is fixed once it starts.
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= RUN;
                        hold_cnt   <= '0;
                        core_rst_q <= 1'b0;
                        rst_done_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                RUN: begin
                    if (bus.soft_rst_req) begin
                        state       <= HOLD;
                        hold_cnt    <= '0;
                        core_rst_q  <= 1'b1;
                        rst_cause_q <= CAUSE_SOFT;
                    end else if (wdt_expire) begin
                        state       <= HOLD;
                        hold_cnt    <= '0;
                        core_rst_q  <= 1'b1;
                        rst_cause_q <= CAUSE_WDT;
                    end
                end

                // An illegal encoding re-enters the hold phase with the core
                // in reset. It does not wait on a synchronizer that is full.
                default: begin
                    state      <= HOLD;
                    hold_cnt   <= '0;
                    core_rst_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.core_rst  = core_rst_q;
    assign bus.rst_done  = rst_done_q;
    assign bus.rst_cause = rst_cause_q;

endmodule : rst_sequencer

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_sequencer
// Directed bench for rst_sequencer with HOLD_CYCLES = 16 and WDT_TIMEOUT = 8,
// clocked at 50 MHz. Watchdog scenarios are compiled when RST_WDT_EN is
// defined. Otherwise the bench confirms the watchdog has no effect.
// Outputs are sampled on the falling edge, and inputs change there too.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

    localparam int HOLD = 16;
    localparam int WDT  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    rst_sequencer_if bus ();

    rst_sequencer #(
        .HOLD_CYCLES (HOLD),
        .WDT_TIMEOUT (WDT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 50 MHz clock, first rising edge at 10 ns.
    always #10 clk = ~clk;

    // One rising edge, then return to the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Step edges until core_rst deasserts or the budget runs out.
    task automatic wait_run(input int budget, output int edges);
        edges = 0;
        while (bus.core_rst !== 1'b0 && edges < budget) begin
            tick();
            edges++;
        end
    endtask

    // ---------------------------------------------------------------- reset
    task automatic test_reset();
        bus.soft_rst_req = 1'b0;
        bus.wdt_en       = 1'b0;
        bus.wdt_kick     = 1'b0;
        rst              = 1'b0;
        #5;
        checks++;
        if (bus.core_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_core_rst: got %b want 1", bus.core_rst);
        end
        checks++;
        if (bus.rst_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_rst_done: got %b want 0", bus.rst_done);
        end
        checks++;
        if (bus.rst_cause !== 2'b00) begin
            errors++;
            $display("FAIL reset_cause: got %b want 00", bus.rst_cause);
        end
        // Clock keeps running with rst low. core_rst must not glitch.
        repeat (4) tick();
        checks++;
        if (bus.core_rst !== 1'b1 || bus.rst_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_clocked: got core_rst=%b rst_done=%b want 1/0",
                     bus.core_rst, bus.rst_done);
        end
    endtask

    // ------------------------------------------- external release (195 ns)
    task automatic test_ext_release();
        int dones;
        dones = 0;
        #(195 - 80);             // test_reset ends at 80 ns
        rst = 1'b1;
        for (int e = 1; e <= HOLD + 4; e++) begin
            tick();
            checks++;
            if (bus.core_rst !== (e < HOLD + 2 ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL ext_core_rst edge %0d: got %b want %b",
                         e, bus.core_rst, (e < HOLD + 2 ? 1'b1 : 1'b0));
            end
            checks++;
            if (bus.rst_done !== (e == HOLD + 2 ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL ext_rst_done edge %0d: got %b want %b",
                         e, bus.rst_done, (e == HOLD + 2 ? 1'b1 : 1'b0));
            end
            if (bus.rst_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ext_done_count: got %0d want 1", dones);
        end
        checks++;
        if (bus.rst_cause !== 2'b00) begin
            errors++;
            $display("FAIL ext_cause: got %b want 00", bus.rst_cause);
        end
    endtask

    // ---------------------------------------------------------- soft reset
    task automatic test_soft_reset();
        bus.soft_rst_req = 1'b1;
        tick();                  // edge N
        bus.soft_rst_req = 1'b0;
        checks++;
        if (bus.core_rst !== 1'b1 || bus.rst_cause !== 2'b01) begin
            errors++;
            $display("FAIL soft_enter: got core_rst=%b cause=%b want 1/01",
                     bus.core_rst, bus.rst_cause);
        end
        for (int k = 1; k <= HOLD; k++) begin
            tick();
            checks++;
            if (bus.core_rst !== (k < HOLD ? 1'b1 : 1'b0) ||
                bus.rst_done !== (k == HOLD ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL soft_hold edge N+%0d: got core_rst=%b rst_done=%b want %b/%b",
                         k, bus.core_rst, bus.rst_done,
                         (k < HOLD ? 1'b1 : 1'b0), (k == HOLD ? 1'b1 : 1'b0));
            end
        end
        tick();
        checks++;
        if (bus.rst_done !== 1'b0 || bus.rst_cause !== 2'b01) begin
            errors++;
            $display("FAIL soft_after: got rst_done=%b cause=%b want 0/01",
                     bus.rst_done, bus.rst_cause);
        end
    endtask

    // ------------------------------------- requests during HOLD are ignored
    task automatic test_ignore_in_hold();
        bus.soft_rst_req = 1'b1;
        tick();                  // edge N, enter HOLD
        bus.soft_rst_req = 1'b0;
        for (int k = 1; k <= HOLD; k++) begin
            bus.soft_rst_req = (k == 5);
            bus.wdt_kick     = (k == 5);
            tick();
            checks++;
            if (bus.core_rst !== (k < HOLD ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL ignore_hold edge N+%0d: got %b want %b",
                         k, bus.core_rst, (k < HOLD ? 1'b1 : 1'b0));
            end
        end
        bus.soft_rst_req = 1'b0;
        bus.wdt_kick     = 1'b0;
        checks++;
        if (bus.rst_cause !== 2'b01) begin
            errors++;
            $display("FAIL ignore_cause: got %b want 01", bus.rst_cause);
        end
    endtask

    // ------------------------------------------ 3 ns rst glitch in mid-HOLD
    task automatic test_mid_hold_glitch();
        int dones;
        dones = 0;
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.core_rst !== 1'b1 || bus.rst_cause !== 2'b00 || bus.rst_done !== 1'b0) begin
            errors++;
            $display("FAIL glitch_async: got core_rst=%b cause=%b rst_done=%b want 1/00/0",
                     bus.core_rst, bus.rst_cause, bus.rst_done);
        end
        #2;
        rst = 1'b1;
        for (int e = 1; e <= HOLD + 2; e++) begin
            tick();
            checks++;
            if (bus.core_rst !== (e < HOLD + 2 ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL glitch_core_rst edge %0d: got %b want %b",
                         e, bus.core_rst, (e < HOLD + 2 ? 1'b1 : 1'b0));
            end
            if (bus.rst_done === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || bus.rst_done !== 1'b1) begin
            errors++;
            $display("FAIL glitch_done: got count=%0d last=%b want 1/1", dones, bus.rst_done);
        end
        checks++;
        if (bus.rst_cause !== 2'b00) begin
            errors++;
            $display("FAIL glitch_cause: got %b want 00", bus.rst_cause);
        end
    endtask

`ifdef RST_WDT_EN
    // ------------------------------------------------------ watchdog expiry
    task automatic test_wdt_expiry();
        int edges;
        bus.wdt_en = 1'b1;       // counter is 0 here
        for (int k = 1; k <= WDT; k++) begin
            tick();
            checks++;
            if (bus.core_rst !== (k == WDT ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL wdt_expiry edge %0d: got %b want %b",
                         k, bus.core_rst, (k == WDT ? 1'b1 : 1'b0));
            end
        end
        checks++;
        if (bus.rst_cause !== 2'b10) begin
            errors++;
            $display("FAIL wdt_cause: got %b want 10", bus.rst_cause);
        end
        wait_run(40, edges);
        checks++;
        if (bus.core_rst !== 1'b0 || edges != HOLD || bus.rst_done !== 1'b1) begin
            errors++;
            $display("FAIL wdt_rerun: got core_rst=%b edges=%0d rst_done=%b want 0/%0d/1",
                     bus.core_rst, edges, bus.rst_done, HOLD);
        end
    endtask

    // ------------------------------------------- kick every 5 cycles, 100x
    task automatic test_wdt_kick();
        int bad;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            bus.wdt_kick = (i % 5 == 4);
            tick();
            if (bus.core_rst !== 1'b0) bad++;
        end
        bus.wdt_kick = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wdt_kick: got %0d reset cycles want 0", bad);
        end
    endtask

    // -------------------------------- kick / soft request on terminal count
    task automatic test_wdt_at_expiry();
        int edges;
        repeat (WDT - 1) tick();  // counter now at WDT-1
        checks++;
        if (bus.core_rst !== 1'b0) begin
            errors++;
            $display("FAIL wdt_pre_kick: got %b want 0", bus.core_rst);
        end
        bus.wdt_kick = 1'b1;
        tick();
        bus.wdt_kick = 1'b0;
        checks++;
        if (bus.core_rst !== 1'b0) begin
            errors++;
            $display("FAIL wdt_kick_at_expiry: got %b want 0", bus.core_rst);
        end
        repeat (WDT - 1) tick();
        checks++;
        if (bus.core_rst !== 1'b0) begin
            errors++;
            $display("FAIL wdt_pre_soft: got %b want 0", bus.core_rst);
        end
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        checks++;
        if (bus.core_rst !== 1'b1 || bus.rst_cause !== 2'b01) begin
            errors++;
            $display("FAIL wdt_soft_at_expiry: got core_rst=%b cause=%b want 1/01",
                     bus.core_rst, bus.rst_cause);
        end
        wait_run(40, edges);
        checks++;
        if (bus.core_rst !== 1'b0 || edges != HOLD) begin
            errors++;
            $display("FAIL wdt_soft_rerun: got core_rst=%b edges=%0d want 0/%0d",
                     bus.core_rst, edges, HOLD);
        end
        bus.wdt_en = 1'b0;
    endtask
`else
    // ------------------------------------- watchdog absent: no expiry ever
    task automatic test_no_wdt();
        int bad;
        int saw_wdt;
        bad     = 0;
        saw_wdt = 0;
        bus.wdt_en   = 1'b1;
        bus.wdt_kick = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (bus.core_rst !== 1'b0) bad++;
            if (bus.rst_cause === 2'b10) saw_wdt++;
        end
        bus.wdt_en = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL no_wdt_core_rst: got %0d reset cycles want 0", bad);
        end
        checks++;
        if (saw_wdt != 0) begin
            errors++;
            $display("FAIL no_wdt_cause10: got %0d cycles with cause 10 want 0", saw_wdt);
        end
        checks++;
        if (bus.rst_cause !== 2'b00) begin
            errors++;
            $display("FAIL no_wdt_cause: got %b want 00", bus.rst_cause);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ext_release();
        test_soft_reset();
        test_ignore_in_hold();
        test_mid_hold_glitch();
`ifdef RST_WDT_EN
        test_wdt_expiry();
        test_wdt_kick();
        test_wdt_at_expiry();
`else
        test_no_wdt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded 1 ms");
        $fatal(1, "time limit reached");
    end

endmodule : tb_rst_sequencer

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: core reset hold length in clk cycles; legal range 1..255.
REQ-002 Parameter WDT_TIMEOUT, default 1024: watchdog expiry in clk cycles; legal range 2..65535.
REQ-003 clk  input  1  system clock; single clock domain; all state on rising edge.
REQ-004 rst  input  1  external reset; asynchronous, active-low.
REQ-005 soft_rst_req  input  1  software reset request; level sampled each cycle.
REQ-006 wdt_en  input  1  watchdog enable.
REQ-007 wdt_kick  input  1  watchdog restart; level sampled each cycle.
REQ-008 core_rst  output  1  reset to CPU/SOPC; active-high, matching RstEnable = 1; registered.
REQ-009 rst_done  output  1  one-cycle pulse when core_rst deasserts.
REQ-010 rst_cause  output  2  cause of the last core reset: 00 external, 01 soft, 10 watchdog; 11 unused.

Function
REQ-011 Internal reset asserts asynchronously with rst low and deasserts through a 2-flop synchronizer, i.e. synchronously.
REQ-012 States: SYNC (synchronizer filling), HOLD (counting), RUN; core_rst = 1 in SYNC and HOLD, 0 in RUN.
REQ-013 SYNC->HOLD on the 2nd rising edge after rst rises, with hold counter loaded to 0.
REQ-014 HOLD increments the 8-bit hold counter each cycle; HOLD->RUN on the edge where counter == HOLD_CYCLES-1.
REQ-015 External-reset latency: core_rst is 0 after the (HOLD_CYCLES+2)th rising edge following rst deassertion.
REQ-016 rst_done = 1 for exactly the first RUN cycle after each HOLD->RUN transition; 0 otherwise.
REQ-017 In RUN, soft_rst_req = 1 at an edge -> HOLD at that edge, counter cleared, rst_cause <= 01.
REQ-018 The watchdog counter (16-bit) counts only in RUN with wdt_en = 1; it clears on wdt_kick, when wdt_en = 0, and outside RUN.
REQ-019 Watchdog expiry: in RUN, counter == WDT_TIMEOUT-1 with wdt_kick = 0 and soft_rst_req = 0 -> HOLD, rst_cause <= 10.
REQ-020 Simultaneous events: kick at expiry cancels expiry; soft request at expiry wins and gives cause 01.
REQ-021 soft_rst_req and wdt_kick in SYNC/HOLD are ignored; the hold is neither extended nor restarted.
REQ-022 rst_cause holds its value across RUN until the next reset event; an external reset sets it to 00.
REQ-023 rst low at any time, including mid-HOLD, immediately forces SYNC with core_rst = 1.

Reset
REQ-024 While rst = 0: state SYNC, core_rst = 1, rst_done = 0, rst_cause = 00, hold and watchdog counters = 0, synchronizer flops = 0.
REQ-025 No output glitches low during rst assertion or the SYNC state.

Configuration
REQ-026 Macro RST_WDT_EN: when defined, the watchdog (REQ-018..020) is compiled in.
REQ-027 Without RST_WDT_EN: no watchdog counter; wdt_en/wdt_kick are accepted but unused; rst_cause never takes 10; all else is unchanged.

Verification
REQ-028 rst low 195 ns, then high, clk 50 MHz, HOLD_CYCLES = 16 -> core_rst = 1 through edge 17 and 0 after edge 18; rst_done pulses once; rst_cause = 00.
REQ-029 In RUN, soft_rst_req = 1 for one cycle at edge N -> core_rst = 1 after edge N, 0 after edge N+16; rst_cause = 01.
REQ-030 RST_WDT_EN defined, WDT_TIMEOUT = 8, wdt_en = 1, no kick -> core_rst rises 8 edges after RUN entry; rst_cause = 10; with a kick every 5 cycles there is no reset over 100 cycles.
REQ-031 Kick coincident with counter == 7 -> no reset; soft_rst_req coincident with expiry -> rst_cause = 01.
REQ-032 rst pulsed low for 3 ns mid-HOLD -> core_rst stays 1; the full 2+16 edge sequence restarts; rst_cause = 00.
REQ-033 RST_WDT_EN undefined, wdt_en = 1, no kick for 2000 cycles -> core_rst stays 0; rst_cause never equals 10.
